// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer (muldiv_seq).
package muldiv_seq_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_FIX  = 2'b10
  } md_state_e;

  localparam int MD_STEPS = 32;

  function automatic logic md_is_div(input md_op_e o);
    return (o == MD_DIV) || (o == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input md_op_e o);
    return (o == MD_MULT) || (o == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate; used both for operand magnitude and result sign fix-up.
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);
  assign y = neg ? (~a + W'(1)) : a;
endmodule

// File: rtl/muldiv_seq.sv
// HI/LO owner: 32-step shift-add multiply / restoring divide on one shared adder.
// Optional MULDIV_EARLY_OUT_EN skips trailing multiply steps once the multiplier is exhausted.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int DATA_W = MD_STEPS,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              mf_req,
  input  logic              mthi,
  input  logic              mtlo,
  input  logic [DATA_W-1:0] wdata,
  input  logic              flush,
  output logic              busy,
  output logic              stall,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  md_state_e state, state_nxt;
  md_op_e    op_q;
  logic [DATA_W-1:0] p_hi, p_lo, opnd, hi_q, lo_q;
  logic [CNT_W-1:0]  cnt;
  logic neg_q, neg_r;
  logic step_en, fix_we;

  // operand capture
  md_op_e op_in;
  logic sgn_in, div_in, dz_in, accept, last, early;
  logic [DATA_W-1:0] rs_abs, rt_abs;
  assign op_in  = md_op_e'(op);
  assign sgn_in = md_is_signed(op_in);
  assign div_in = md_is_div(op_in);
  assign dz_in  = div_in && (rt_data == '0);
  assign accept = (state == MD_IDLE) && start && !flush;
  assign last   = (cnt == CNT_W'(DATA_W-1));

  muldiv_signfix #(.W(DATA_W)) u_abs_rs (.a(rs_data), .neg(sgn_in & rs_data[DATA_W-1]), .y(rs_abs));
  muldiv_signfix #(.W(DATA_W)) u_abs_rt (.a(rt_data), .neg(sgn_in & rt_data[DATA_W-1]), .y(rt_abs));

  // shared adder: add for multiply, compare-subtract (carry = no borrow) for divide
  logic [DATA_W:0]   add_a, add_b;
  logic              add_ci;
  logic [DATA_W+1:0] add_res;
  always_comb begin
    if (md_is_div(op_q)) begin
      add_a  = {p_hi, p_lo[DATA_W-1]};
      add_b  = ~{1'b0, opnd};
      add_ci = 1'b1;
    end else begin
      add_a  = {1'b0, p_hi};
      add_b  = p_lo[0] ? {1'b0, opnd} : '0;
      add_ci = 1'b0;
    end
  end
  assign add_res = {1'b0, add_a} + {1'b0, add_b} + {{(DATA_W+1){1'b0}}, add_ci};

  logic [2*DATA_W-1:0] mul_nxt, mul_sh;
  assign mul_nxt = {add_res[DATA_W:0], p_lo[DATA_W-1:1]};

`ifdef MULDIV_EARLY_OUT_EN
  // low (DATA_W-1-cnt) bits of p_lo after this step are the unconsumed multiplier
  logic [DATA_W-1:0] rem_mask;
  assign rem_mask = {DATA_W{1'b1}} >> (cnt + CNT_W'(1));
  assign early    = !md_is_div(op_q) && ((mul_nxt[DATA_W-1:0] & rem_mask) == '0);
  assign mul_sh   = early ? (mul_nxt >> (CNT_W'(DATA_W-1) - cnt)) : mul_nxt;
`else
  assign early  = 1'b0;
  assign mul_sh = mul_nxt;
`endif

  // result fix-up
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix;
  muldiv_signfix #(.W(2*DATA_W)) u_fix_prod (.a({p_hi, p_lo}), .neg(neg_q), .y(prod_fix));
  muldiv_signfix #(.W(DATA_W))   u_fix_quo  (.a(p_lo), .neg(neg_q), .y(quo_fix));
  muldiv_signfix #(.W(DATA_W))   u_fix_rem  (.a(p_hi), .neg(neg_r), .y(rem_fix));

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MD_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (accept) state_nxt = MD_RUN;
      MD_RUN:  if (flush) state_nxt = MD_IDLE;
               else if (last || early) state_nxt = MD_FIX;
      default: state_nxt = MD_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != MD_IDLE);
    step_en = (state == MD_RUN) && !flush;
    fix_we  = (state == MD_FIX) && !flush;
    stall   = (start | mf_req | mthi | mtlo) & busy;
  end

  // datapath and HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_hi <= '0; p_lo <= '0; opnd <= '0; cnt <= '0;
      neg_q <= 1'b0; neg_r <= 1'b0; op_q <= MD_MULT;
      hi_q <= '0; lo_q <= '0;
    end else begin
      if (accept) begin
        p_hi  <= '0;
        p_lo  <= dz_in ? rs_data : rs_abs;
        opnd  <= rt_abs;
        cnt   <= '0;
        op_q  <= op_in;
        neg_q <= sgn_in && !dz_in && (rs_data[DATA_W-1] ^ rt_data[DATA_W-1]);
        neg_r <= sgn_in && !dz_in && rs_data[DATA_W-1];
      end else if (step_en) begin
        cnt <= cnt + CNT_W'(1);
        if (md_is_div(op_q)) begin
          p_hi <= add_res[DATA_W+1] ? add_res[DATA_W-1:0] : add_a[DATA_W-1:0];
          p_lo <= {p_lo[DATA_W-2:0], add_res[DATA_W+1]};
        end else begin
          {p_hi, p_lo} <= mul_sh;
        end
      end
      if (fix_we) begin
        if (md_is_div(op_q)) begin
          hi_q <= rem_fix;
          lo_q <= quo_fix;
        end else begin
          {hi_q, lo_q} <= prod_fix;
        end
      end else if (!busy && !start) begin
        if (mthi) hi_q <= wdata;
        if (mtlo) lo_q <= wdata;
      end
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: vector table plus stall/flush/reset sequences.
module tb_muldiv_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_data = '0, rt_data = '0, wdata = '0;
  logic        mf_req = 1'b0, mthi = 1'b0, mtlo = 1'b0, flush = 1'b0;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs_data(rs_data), .rt_data(rt_data),
    .mf_req(mf_req), .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .flush(flush),
    .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs, rt, hi, lo;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // issue one op, wait for busy to fall; returns busy cycle count
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (cyc < 100) begin
      tick();
      cyc++;
      if (!busy) break;
    end
    if (busy) begin
      n_cmp++; n_err++;
      $display("FAIL timeout: busy still high after %0d cycles", cyc);
    end
  endtask

  initial begin
    int cyc;
    logic [31:0] prev_hi, prev_lo;
    vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{2'b11, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
    vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[6]  = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
    vecs[7]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8]  = '{2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[9]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[10] = '{2'b00, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000};
    vecs[11] = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14};

    // reset state
    #12;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    rst_n = 1'b1;
    tick();
    mf_req = 1'b1; #1;
    chk("idle_stall", {31'b0, stall}, 32'd0);
    mf_req = 1'b0;

    // vector table
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, cyc);
      chk($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
      chk($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
`ifdef MULDIV_EARLY_OUT_EN
      chk($sformatf("vec%0d_lat_le33", i), {31'b0, cyc <= 33}, 32'd1);
`else
      chk($sformatf("vec%0d_lat", i), cyc, 32'd33);
`endif
    end

`ifdef MULDIV_EARLY_OUT_EN
    run_op(2'b01, 32'd3, 32'd5, cyc);
    chk("early_lat_le4", {31'b0, cyc <= 4}, 32'd1);
    chk("early_lo", lo, 32'd15);
    chk("early_hi", hi, 32'd0);
`endif

    // stall window: HI/LO frozen, requests while busy ignored
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'd0;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    op = 2'b01; rs_data = 32'd6; rt_data = 32'd7; start = 1'b1;
    tick();
    start = 1'b0; mf_req = 1'b1;
    for (int i = 0; i < 33; i++) begin
      if (i == 5) begin start = 1'b1; op = 2'b01; rs_data = 32'd1; rt_data = 32'd1; end
      if (i == 6) begin start = 1'b0; mthi = 1'b1; wdata = 32'h0000BEEF; end
      if (i == 7) mthi = 1'b0;
      #1;
      chk($sformatf("stall_c%0d", i), {29'b0, stall, hi == 32'd0, lo == 32'd0}, 32'd7);
      tick();
    end
    chk("stall_end", {31'b0, stall}, 32'd0);
    chk("mul42_lo", lo, 32'd42);
    chk("mul42_hi", hi, 32'd0);
    mf_req = 1'b0;

    // flush mid-divide
    prev_hi = hi; prev_lo = lo;
    op = 2'b11; rs_data = 32'd1000; rt_data = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_hi", hi, prev_hi);
    chk("flush_lo", lo, prev_lo);
    repeat (40) tick();
    chk("flush_hold_lo", lo, prev_lo);

    // MTHI, then MTHI+MTLO together
    mthi = 1'b1; wdata = 32'h1234;
    tick();
    mthi = 1'b0;
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_lo", lo, prev_lo);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFE0001;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    chk("mtboth_hi", hi, 32'hCAFE0001);
    chk("mtboth_lo", lo, 32'hCAFE0001);

    // flush with start in IDLE: start dropped
    op = 2'b01; rs_data = 32'd2; rt_data = 32'd2; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", {31'b0, busy}, 32'd0);

    // start beats simultaneous MTHI
    op = 2'b01; rs_data = 32'd9; rt_data = 32'd9; start = 1'b1; mthi = 1'b1; wdata = 32'h5555;
    tick();
    start = 1'b0; mthi = 1'b0;
    chk("start_wins_hi", hi, 32'hCAFE0001);
    cyc = 0;
    while (busy && cyc < 100) begin tick(); cyc++; end
    chk("start_wins_lo", lo, 32'd81);
    chk("start_wins_hi_end", hi, 32'd0);

    // async reset mid-run
    run_op(2'b01, 32'd5, 32'd5, cyc);
    op = 2'b10; rs_data = 32'd77; rt_data = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
